// File: rtl/saber_pwm_driver_pkg.sv
// Shared definitions for the lightsaber PWM driver.
// Holds the blade state encoding, PWM geometry, the default ramp step and the
// duty scaling helper used by every colour channel.
package saber_pwm_driver_pkg;

  localparam int unsigned PwmWidth        = 8;
  localparam int unsigned PwmPeriod       = 256;
  localparam int unsigned DefaultRampStep = 8;

  typedef enum logic [1:0] {
    StOff     = 2'd0,
    StIgnite  = 2'd1,
    StOn      = 2'd2,
    StRetract = 2'd3
  } blade_state_e;

  // duty = (colour * (bright + 1)) >> 8, 17-bit product, truncated.
  // bright = 255 passes the colour through unchanged; bright = 0 gives colour >> 8 = 0.
  function automatic logic [PwmWidth-1:0] scale_duty(input logic [PwmWidth-1:0] colour,
                                                     input logic [PwmWidth-1:0] bright);
    logic [PwmWidth:0]   bright_p1;
    logic [2*PwmWidth:0] prod;
    bright_p1 = {1'b0, bright} + {{PwmWidth{1'b0}}, 1'b1};
    prod      = {{(PwmWidth + 1){1'b0}}, colour} * {{PwmWidth{1'b0}}, bright_p1};
    return PwmWidth'(prod >> PwmWidth);
  endfunction

endpackage

// File: rtl/saber_pwm_driver_if.sv
// Colour/request/drive bundle of the lightsaber PWM driver.
//   Ri, Gi, Bi : colour intensities (0..255)
//   saber_on   : level request, 1 = blade lit
//   Rp, Gp, Bp : LED PWM drives
//   state      : blade state (0 OFF, 1 IGNITE, 2 ON, 3 RETRACT)
//   busy       : high while igniting or retracting
// master = controller side, slave = driver side.
interface saber_pwm_driver_if;

  logic [7:0] Ri;
  logic [7:0] Gi;
  logic [7:0] Bi;
  logic       saber_on;
  logic       Rp;
  logic       Gp;
  logic       Bp;
  logic [1:0] state;
  logic       busy;

  modport master (
    output Ri, Gi, Bi, saber_on,
    input  Rp, Gp, Bp, state, busy
  );

  modport slave (
    input  Ri, Gi, Bi, saber_on,
    output Rp, Gp, Bp, state, busy
  );

endinterface

// File: rtl/saber_pwm_channel.sv
// One LED colour channel: scales the colour by the brightness written on the
// same wrap edge, latches the result as the duty for the coming period and
// compares it against the shared period counter.
//   clk, rst  : clock, asynchronous active-high reset
//   wrap_i    : high in the cycle whose rising edge takes cnt 255 -> 0
//   en_i      : blade not OFF (registered state)
//   colour_i  : current colour intensity
//   bright_i  : brightness value being written on this edge
//   cnt_i     : registered period counter
//   pwm_o     : LED drive
module saber_pwm_channel
  import saber_pwm_driver_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wrap_i,
  input  logic                en_i,
  input  logic [PwmWidth-1:0] colour_i,
  input  logic [PwmWidth-1:0] bright_i,
  input  logic [PwmWidth-1:0] cnt_i,
  output logic                pwm_o
);

  logic [PwmWidth-1:0] duty_q;

  // Duty only moves on wrap edges so a colour change never splits a period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
    end else if (wrap_i) begin
      duty_q <= scale_duty(colour_i, bright_i);
    end
  end

  // Pure function of registers: duty 255 leaves cnt = 255 low, duty 0 is always low.
  assign pwm_o = en_i && (cnt_i < duty_q);

endmodule

// File: rtl/saber_pwm_driver.sv
// Lightsaber RGB PWM driver: free-running 256-cycle period counter, blade
// brightness ramp and OFF/IGNITE/ON/RETRACT state machine, feeding three
// saber_pwm_channel instances.
//   RAMP_STEP : brightness change per PWM period while ramping (1..255)
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : slave side of saber_pwm_driver_if (colours, request, drives, status)
module saber_pwm_driver
  import saber_pwm_driver_pkg::*;
#(
  parameter int unsigned RAMP_STEP = DefaultRampStep
) (
  input  logic                clk,
  input  logic                rst,
  saber_pwm_driver_if.slave   bus
);

  localparam logic [PwmWidth-1:0] Step = PwmWidth'(RAMP_STEP);

  logic [PwmWidth-1:0] cnt_q;
  logic [PwmWidth-1:0] bright_q, bright_d;
  blade_state_e        state_q, state_d;
  logic                busy_q, busy_d;

  logic                wrap;
  logic [PwmWidth:0]   up_sum;
  logic [PwmWidth-1:0] bright_up, bright_dn;
  logic                blade_en;

  assign wrap      = (cnt_q == {PwmWidth{1'b1}});
  assign up_sum    = {1'b0, bright_q} + {1'b0, Step};
  assign bright_up = up_sum[PwmWidth] ? {PwmWidth{1'b1}} : up_sum[PwmWidth-1:0];
  assign bright_dn = (bright_q > Step) ? (bright_q - Step) : '0;

  // A saber_on change always wins over a ramp step on the same edge; the
  // brightness is then held where it was.
  always_comb begin
    state_d  = state_q;
    bright_d = bright_q;
    unique case (state_q)
      StOff: begin
        if (bus.saber_on) state_d = StIgnite;
      end
      StIgnite: begin
        if (!bus.saber_on) begin
          state_d = StRetract;
        end else if (wrap) begin
          bright_d = bright_up;
          if (bright_up == {PwmWidth{1'b1}}) state_d = StOn;
        end
      end
      StOn: begin
        if (!bus.saber_on) state_d = StRetract;
      end
      StRetract: begin
        if (bus.saber_on) begin
          state_d = StIgnite;
        end else if (wrap) begin
          bright_d = bright_dn;
          if (bright_dn == '0) state_d = StOff;
        end
      end
    endcase
    busy_d = (state_d == StIgnite) || (state_d == StRetract);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      bright_q <= '0;
      state_q  <= StOff;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_q + 1'b1;
      bright_q <= bright_d;
      state_q  <= state_d;
      busy_q   <= busy_d;
    end
  end

  assign blade_en  = (state_q != StOff);
  assign bus.state = state_q;
  assign bus.busy  = busy_q;

  saber_pwm_channel u_chan_r (
    .clk      (clk),
    .rst      (rst),
    .wrap_i   (wrap),
    .en_i     (blade_en),
    .colour_i (bus.Ri),
    .bright_i (bright_d),
    .cnt_i    (cnt_q),
    .pwm_o    (bus.Rp)
  );

  saber_pwm_channel u_chan_g (
    .clk      (clk),
    .rst      (rst),
    .wrap_i   (wrap),
    .en_i     (blade_en),
    .colour_i (bus.Gi),
    .bright_i (bright_d),
    .cnt_i    (cnt_q),
    .pwm_o    (bus.Gp)
  );

  saber_pwm_channel u_chan_b (
    .clk      (clk),
    .rst      (rst),
    .wrap_i   (wrap),
    .en_i     (blade_en),
    .colour_i (bus.Bi),
    .bright_i (bright_d),
    .cnt_i    (cnt_q),
    .pwm_o    (bus.Bp)
  );

endmodule

// File: tb/tb_saber_pwm_driver.sv
// Bench for saber_pwm_driver: directed blade scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model of the blade (counter, brightness, state, duties).
module tb_saber_pwm_driver;
  import saber_pwm_driver_pkg::*;

  localparam int Step = 8;

  logic clk = 1'b0;
  logic rst;

  saber_pwm_driver_if bus ();

  saber_pwm_driver #(
    .RAMP_STEP (Step)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: blade counter, brightness, state (0..3) and duties.
  int m_cnt, m_b, m_st;
  int m_d[3];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int colour(input int ch);
    case (ch)
      0:       return int'(bus.Ri);
      1:       return int'(bus.Gi);
      default: return int'(bus.Bi);
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_b   = 0;
    m_st  = 0;
    for (int i = 0; i < 3; i++) m_d[i] = 0;
  endtask

  // One rising edge of the blade rules, using the inputs applied now.
  task automatic model_step();
    bit wrap;
    int nb, ns;
    wrap = (m_cnt == PwmPeriod - 1);
    nb   = m_b;
    ns   = m_st;
    case (m_st)
      0: if (bus.saber_on) ns = 1;
      1: begin
        if (!bus.saber_on) ns = 3;
        else if (wrap) begin
          nb = (m_b + Step > 255) ? 255 : m_b + Step;
          if (nb == 255) ns = 2;
        end
      end
      2: if (!bus.saber_on) ns = 3;
      default: begin
        if (bus.saber_on) ns = 1;
        else if (wrap) begin
          nb = (m_b - Step < 0) ? 0 : m_b - Step;
          if (nb == 0) ns = 0;
        end
      end
    endcase
    if (wrap) for (int i = 0; i < 3; i++) m_d[i] = ((colour(i) * (nb + 1)) / 256) % 256;
    m_b   = nb;
    m_st  = ns;
    m_cnt = (m_cnt + 1) % PwmPeriod;
  endtask

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      int exp_v, act_v;
      @(negedge clk);
      exp_v = (m_st << 4) | (((m_st == 1) || (m_st == 3)) ? 8 : 0);
      for (int i = 0; i < 3; i++)
        if ((m_st != 0) && (m_cnt < m_d[i])) exp_v |= (4 >> i);
      act_v = (int'(bus.state) << 4) | (int'(bus.busy) << 3) |
              (int'(bus.Rp) << 2) | (int'(bus.Gp) << 1) | int'(bus.Bp);
      check("outputs{state,busy,Rp,Gp,Bp}", act_v, exp_v);
    end
  end

  // Advance one edge; returns 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic run_wraps(input int n);
    int w = 0;
    while (w < n) begin
      cycle();
      if (m_cnt == 0) w++;
    end
  endtask

  task automatic wait_state(input int target, input int limit, output int n);
    n = 0;
    while ((int'(bus.state) != target) && (n < limit)) begin
      cycle();
      n++;
    end
    check("wait_state", int'(bus.state), target);
  endtask

  task automatic wait_cnt(input int c);
    int n = 0;
    while ((m_cnt != c) && (n < PwmPeriod)) begin
      cycle();
      n++;
    end
  endtask

  // Samples the drives now and after each of the next n-1 edges (n samples).
  task automatic count_pwm(input int n, output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    for (int i = 0; i < n; i++) begin
      r += int'(bus.Rp);
      g += int'(bus.Gp);
      b += int'(bus.Bp);
      cycle();
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int n, r, g, b;
    rst          = 1'b1;
    bus.Ri       = 8'd0;
    bus.Gi       = 8'd0;
    bus.Bi       = 8'd0;
    bus.saber_on = 1'b0;
    model_reset();
    repeat (3) cycle();
    check("reset_state", int'(bus.state), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_rgb", {29'd0, bus.Rp, bus.Gp, bus.Bp}, 0);

    // Full ignite from OFF.
    bus.Ri = 8'd255; bus.Gi = 8'd0; bus.Bi = 8'd128;
    bus.saber_on = 1'b1;
    rst = 1'b0;
    cycle();
    check("ignite_entry_state", int'(bus.state), 1);
    check("ignite_entry_busy", int'(bus.busy), 1);
    wait_state(2, 9000, n);
    check("ignite_len_edges", n, 255 + 31 * 256);
    check("on_busy", int'(bus.busy), 0);
    count_pwm(256, r, g, b);
    check("on_r_high", r, 255);
    check("on_g_high", g, 0);
    check("on_b_high", b, 128);

    // Retract from full brightness back to OFF.
    bus.saber_on = 1'b0;
    cycle();
    check("retract_entry", int'(bus.state), 3);
    wait_state(0, 9000, n);

    // Mid-ramp duty at B = 128.
    bus.saber_on = 1'b1;
    cycle();
    run_wraps(16);
    count_pwm(256, r, g, b);
    check("midramp_r_high", r, 128);
    check("midramp_b_high", b, 64);

    // Reset mid-ramp, then abort and re-ignite.
    reset_pulse();
    check("midramp_reset_state", int'(bus.state), 0);
    cycle();
    check("reignite_state", int'(bus.state), 1);
    run_wraps(8);
    bus.saber_on = 1'b0;
    cycle();
    check("abort_state", int'(bus.state), 3);
    run_wraps(4);
    bus.saber_on = 1'b1;
    cycle();
    check("resume_state", int'(bus.state), 1);
    run_wraps(1);
    count_pwm(256, r, g, b);
    check("resume_r_high_b40", r, 40);

    // Natural retract from B = 64.
    run_wraps(2);
    bus.saber_on = 1'b0;
    cycle();
    check("natret_entry", int'(bus.state), 3);
    run_wraps(7);
    check("natret_7", int'(bus.state), 3);
    run_wraps(1);
    check("natret_8_state", int'(bus.state), 0);
    check("natret_8_rp", int'(bus.Rp), 0);

    // Asynchronous reset at cnt = 100 in IGNITE.
    bus.saber_on = 1'b1;
    cycle();
    run_wraps(16);
    wait_cnt(100);
    check("async_pre_rp", int'(bus.Rp), 1);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_outs", {27'd0, bus.state, bus.busy, bus.Rp, bus.Gp, bus.Bp}, 0);
    cycle();
    cycle();
    rst = 1'b0;

    // Colour change mid-period while ON.
    wait_state(2, 9000, n);
    wait_cnt(100);
    bus.Ri = 8'd0;
    count_pwm(156, r, g, b);
    check("colchg_rest_of_period", r, 155);
    count_pwm(256, r, g, b);
    check("colchg_next_period", r, 0);

    // Randomized phase.
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 399) == 0) bus.saber_on = ~bus.saber_on;
      if ($urandom_range(0, 149) == 0) begin
        bus.Ri = 8'($urandom);
        bus.Gi = 8'($urandom);
        bus.Bi = 8'($urandom);
      end
      if ($urandom_range(0, 4999) == 0) reset_pulse();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/saber_pwm_driver.md
SABER_PWM_DRIVER -- requirements
Module: saber_pwm_driver

Interface
REQ-001 Parameter: RAMP_STEP, 8, brightness change per PWM period during ignite/retract (1..255).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 Ri  input  8  red intensity from the colour registers (0..255).
REQ-005 Gi  input  8  green intensity from the colour registers (0..255).
REQ-006 Bi  input  8  blue intensity from the colour registers (0..255).
REQ-007 saber_on  input  1  level request: 1 = blade lit, 0 = blade off.
REQ-008 Rp  output  1  red LED PWM drive.
REQ-009 Gp  output  1  green LED PWM drive.
REQ-010 Bp  output  1  blue LED PWM drive.
REQ-011 state  output  2  blade state: 0 OFF, 1 IGNITE, 2 ON, 3 RETRACT.
REQ-012 busy  output  1  high in IGNITE or RETRACT.

Function
REQ-013 8-bit free-running period counter cnt, 0..255 then wraps to 0; one PWM period = 256 cycles.
REQ-014 "Wrap edge" = the clock edge where cnt goes 255 -> 0.
REQ-015 8-bit brightness register B; only changes on wrap edges.
REQ-016 OFF -> IGNITE on any edge with saber_on=1; B unchanged (0).
REQ-017 IGNITE: on each wrap edge B <= min(B+RAMP_STEP, 255); if that new B is 255, state <= ON on the same edge.
REQ-018 IGNITE -> RETRACT on any edge with saber_on=0; B held at its current value.
REQ-019 ON -> RETRACT on any edge with saber_on=0.
REQ-020 RETRACT: on each wrap edge B <= max(B-RAMP_STEP, 0); if that new B is 0, state <= OFF on the same edge.
REQ-021 RETRACT -> IGNITE on any edge with saber_on=1; B held.
REQ-022 Per channel, latched duty D_x; on each wrap edge D_x <= (C_x * (B_new+1)) >> 8.
REQ-023 In REQ-022, C_x is the current colour input and B_new is the brightness written on the same edge; the product is 17 bits and truncated, never saturated.
REQ-024 D_x is held constant between wrap edges; colour changes take effect from the next period only (latency up to 256 cycles).
REQ-025 Each PWM output = (cnt < D_x) AND (state != OFF), derived only from registers; duty 255 gives 255 high cycles of 256, duty 0 gives constant 0.
REQ-026 busy and state reflect the registered state with no added latency.

Reset
REQ-027 rst asserted forces immediately: cnt=0, B=0, all D_x=0, state=OFF, Rp=Gp=Bp=0, busy=0.
REQ-028 Reset asserted mid-ramp or mid-period discards all progress; after release, the first period starts at cnt=0.

Structure
REQ-029 Shared package holds: state encodings (OFF/IGNITE/ON/RETRACT), PWM width 8, period 256, default RAMP_STEP.
REQ-030 One sub-module saber_pwm_channel (duty scale, duty latch, compare) is instantiated three times (R, G, B).
REQ-031 Counter, brightness and state machine live in the top module.

Verification
REQ-032 Async reset: assert rst in IGNITE at cnt=100 -> Rp/Gp/Bp=0, state=0, busy=0 before the next clk edge.
REQ-033 Full ignite: Ri=255, Gi=0, Bi=128, saber_on=1 from OFF -> state=1 next edge; B=8,16,..,248,255; state=2 after the 32nd wrap edge.
REQ-034 In ON for the REQ-033 stimulus, per 256-cycle period: Rp high 255 cycles, Bp high 128, Gp 0.
REQ-035 Mid-ramp duty: after 16 wraps in IGNITE (B=128) with Ri=255 -> D_R=128, Rp high exactly 128 of 256 cycles.
REQ-036 Abort and re-ignite: drop saber_on at B=64 -> state=3 next edge; B=56,48,..; raise saber_on at B=32 -> state=1, B resumes 40,48,...
REQ-037 Natural retract: B=64 with saber_on=0 -> 8 wrap edges later B=0 and state=0, outputs 0.
REQ-038 Colour change mid-period: in ON, change Ri 255 -> 0 at cnt=100 -> Rp keeps old duty through cnt=254, then is 0 for the entire next period.
